// File: rtl/decode_issue_ctrl_if.sv
// decode_issue_ctrl_if
//   Groups the decode-slot, writeback and issue-control signals of the
//   decode issue controller.
//   master: decoder / register file / writeback side (drives slot + retire)
//   slave : decode_issue_ctrl (drives issue/stall/bubble and status)
interface decode_issue_ctrl_if;
    // decode slot
    logic        id_valid;
    logic        id_rd1_en;
    logic        id_rd2_en;
    logic [2:0]  id_rd1;
    logic [2:0]  id_rd2;
    logic        id_wr_en;
    logic [2:0]  id_wr;
    logic        id_halt;
    logic        flush;
    // retire side
    logic        wb_en;
    logic [2:0]  wb_reg;
    // controller outputs
    logic        issue;
    logic        stall;
    logic        bubble;
    logic        halted;
    logic [7:0]  busy_map;
    logic [15:0] stall_cnt;
    logic        err;

    modport master (
        output id_valid, id_rd1_en, id_rd2_en, id_rd1, id_rd2,
               id_wr_en, id_wr, id_halt, flush, wb_en, wb_reg,
        input  issue, stall, bubble, halted, busy_map, stall_cnt, err
    );

    modport slave (
        input  id_valid, id_rd1_en, id_rd2_en, id_rd1, id_rd2,
               id_wr_en, id_wr, id_halt, flush, wb_en, wb_reg,
        output issue, stall, bubble, halted, busy_map, stall_cnt, err
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   Scoreboard issue controller for the decode stage. Keeps a per-register
//   count of in-flight writers, stalls decode on RAW hazards the register
//   file bypass cannot cover, stalls a writer whose counter is full, and
//   drains the pipeline after HALT issues.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : decode_issue_ctrl_if.slave (decode slot, retire, issue controls,
//          busy_map, stall_cnt, halted, err)
module decode_issue_ctrl #(
    parameter int CNT_W     = 2,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_DRAIN, S_HALTED} state_e;

    state_e                  state_q, state_d;
    logic [7:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]              busy_map_q, busy_map_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;
    logic                    err_q, err_d;

    logic [7:0]              pend;
    logic [7:0]              inc_vec;
    logic [7:0]              dec_vec;
    logic                    haz;
    logic                    slot_live;
    logic                    issue;
    logic                    stall;
    logic                    all_zero;

    // A register is pending unless its last writer retires this very cycle
    // and the register file forwards the write to the read port.
    always_comb begin
        pend = '0;
        for (int r = 0; r < 8; r++) begin
            pend[r] = (cnt_q[r] != '0) &&
                      !(BYPASS_WB && bus.wb_en && (bus.wb_reg == 3'(r)) &&
                        (cnt_q[r] == CNT_ONE));
        end
    end

    // The write-side check ignores the bypass: a full counter must drop
    // before another writer can be accounted for.
    assign haz = (bus.id_rd1_en && pend[bus.id_rd1]) ||
                 (bus.id_rd2_en && pend[bus.id_rd2]) ||
                 (bus.id_wr_en  && (cnt_q[bus.id_wr] == CNT_MAX));

    // rst gates the slot so nothing issues while reset is held.
    assign slot_live = rst && bus.id_valid && !bus.flush &&
                       ((state_q == S_RUN) || (state_q == S_STALL));
    assign issue     = slot_live && !haz;
    assign stall     = (slot_live && haz) ||
                       (state_q == S_DRAIN) || (state_q == S_HALTED);
    assign all_zero  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (issue && bus.id_halt)      state_d = S_DRAIN;
                else if (stall)                state_d = S_STALL;
            end
            S_STALL: begin
                if (issue && bus.id_halt)      state_d = S_DRAIN;
                else if (issue || bus.flush)   state_d = S_RUN;
            end
            S_DRAIN: begin
                if (bus.flush)                 state_d = S_RUN;
                else if (all_zero && !bus.wb_en) state_d = S_HALTED;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < 8; r++) begin
            inc_vec[r] = issue && bus.id_wr_en && (bus.id_wr == 3'(r));
            dec_vec[r] = bus.wb_en && (bus.wb_reg == 3'(r));
        end
    end

    // A simultaneous issue and retire of the same register cancel out.
    // Out-of-range updates leave the counter alone and raise err.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 0; r < 8; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0)      err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // busy_map is taken from the next counts so it always equals
    // (count != 0) for the current cycle.
    always_comb begin
        busy_map_d = '0;
        for (int r = 0; r < 8; r++) begin
            busy_map_d[r] = (cnt_d[r] != '0);
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            busy_map_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_map_q  <= busy_map_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.bubble    = !issue;
    assign bus.halted    = (state_q == S_HALTED);
    assign bus.busy_map  = busy_map_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl
//   Drives one stimulus stream into two controllers (bypass present and
//   absent). Expected {issue,stall,bubble} per cycle are queued when the
//   slot is driven and popped by a monitor mid-cycle; registered outputs
//   are checked after each clock edge.
module tb_decode_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid, id_rd1_en, id_rd2_en, id_wr_en, id_halt, flush, wb_en;
    logic [2:0] id_rd1, id_rd2, id_wr, wb_reg;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [15:0] sc_b  = '0;
    logic [15:0] sc_n  = '0;

    string      tag_q[$];
    logic [2:0] eb_q[$];
    logic [2:0] en_q[$];

    decode_issue_ctrl_if bb ();
    decode_issue_ctrl_if bn ();

    decode_issue_ctrl #(.CNT_W(2), .BYPASS_WB(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bb));
    decode_issue_ctrl #(.CNT_W(2), .BYPASS_WB(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bn));

    assign bb.id_valid = id_valid;   assign bn.id_valid = id_valid;
    assign bb.id_rd1_en = id_rd1_en; assign bn.id_rd1_en = id_rd1_en;
    assign bb.id_rd2_en = id_rd2_en; assign bn.id_rd2_en = id_rd2_en;
    assign bb.id_rd1 = id_rd1;       assign bn.id_rd1 = id_rd1;
    assign bb.id_rd2 = id_rd2;       assign bn.id_rd2 = id_rd2;
    assign bb.id_wr_en = id_wr_en;   assign bn.id_wr_en = id_wr_en;
    assign bb.id_wr = id_wr;         assign bn.id_wr = id_wr;
    assign bb.id_halt = id_halt;     assign bn.id_halt = id_halt;
    assign bb.flush = flush;         assign bn.flush = flush;
    assign bb.wb_en = wb_en;         assign bn.wb_en = wb_en;
    assign bb.wb_reg = wb_reg;       assign bn.wb_reg = wb_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic idle();
        id_valid = 0; id_rd1_en = 0; id_rd2_en = 0; id_wr_en = 0;
        id_halt = 0; flush = 0; wb_en = 0;
        id_rd1 = 0; id_rd2 = 0; id_wr = 0; wb_reg = 0;
    endtask

    // eb/en: expected {issue,stall,bubble} for bypass / no-bypass DUT this
    // cycle; ebusy: busy_map after the edge.
    task automatic tick(input string tag, input logic [2:0] eb, input logic [2:0] en,
                        input logic [7:0] ebusy);
        tag_q.push_back(tag);
        eb_q.push_back(eb);
        en_q.push_back(en);
        if (rst && eb[1] && sc_b != 16'hFFFF) sc_b = sc_b + 16'd1;
        if (rst && en[1] && sc_n != 16'hFFFF) sc_n = sc_n + 16'd1;
        @(negedge clk);
        chk({tag, ".busy_b"}, 32'(bb.busy_map), 32'(ebusy));
        chk({tag, ".busy_n"}, 32'(bn.busy_map), 32'(ebusy));
        chk({tag, ".scnt_b"}, 32'(bb.stall_cnt), 32'(sc_b));
        chk({tag, ".scnt_n"}, 32'(bn.stall_cnt), 32'(sc_n));
    endtask

    always @(negedge clk) begin : mon
        string      t;
        logic [2:0] e1, e2;
        #2;
        if (tag_q.size() != 0) begin
            t  = tag_q.pop_front();
            e1 = eb_q.pop_front();
            e2 = en_q.pop_front();
            chk({t, ".isb_b"}, 32'({bb.issue, bb.stall, bb.bubble}), 32'(e1));
            chk({t, ".isb_n"}, 32'({bn.issue, bn.stall, bn.bubble}), 32'(e2));
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);

        // reset holds issue low even with a clean valid slot
        id_valid = 1;
        tick("rst", 3'b001, 3'b001, 8'h00);
        chk("rst.halted", 32'(bb.halted), 0);
        chk("rst.err", 32'(bb.err), 0);
        rst = 1'b1;

        // RAW on r3, bypass vs no bypass
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 3;
        tick("s1_add", 3'b100, 3'b100, 8'h08);
        idle(); id_valid = 1; id_rd1_en = 1; id_rd1 = 3;
        tick("s1_raw", 3'b011, 3'b011, 8'h08);
        wb_en = 1; wb_reg = 3;
        tick("s1_wb", 3'b100, 3'b011, 8'h00);
        wb_en = 0;
        tick("s1_after", 3'b100, 3'b100, 8'h00);

        // counter full on r5
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 5;
        tick("s2_w1", 3'b100, 3'b100, 8'h20);
        tick("s2_w2", 3'b100, 3'b100, 8'h20);
        tick("s2_w3", 3'b100, 3'b100, 8'h20);
        tick("s2_w4", 3'b011, 3'b011, 8'h20);
        wb_en = 1; wb_reg = 5;
        tick("s2_w4wb", 3'b011, 3'b011, 8'h20);
        wb_en = 0;
        tick("s2_w4go", 3'b100, 3'b100, 8'h20);
        idle(); wb_en = 1; wb_reg = 5;
        tick("s2_r1", 3'b001, 3'b001, 8'h20);
        tick("s2_r2", 3'b001, 3'b001, 8'h20);
        tick("s2_r3", 3'b001, 3'b001, 8'h00);
        chk("s2.err_b", 32'(bb.err), 0);
        chk("s2.err_n", 32'(bn.err), 0);

        // HALT with two writers in flight
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 1;
        tick("s3_w1", 3'b100, 3'b100, 8'h02);
        id_wr = 2;
        tick("s3_w2", 3'b100, 3'b100, 8'h06);
        idle(); id_valid = 1; id_halt = 1;
        tick("s3_halt", 3'b100, 3'b100, 8'h06);
        idle();
        tick("s3_drain", 3'b011, 3'b011, 8'h06);
        wb_en = 1; wb_reg = 1;
        tick("s3_rt1", 3'b011, 3'b011, 8'h04);
        wb_reg = 2;
        tick("s3_rt2", 3'b011, 3'b011, 8'h00);
        chk("s3.halt_early", 32'(bb.halted), 0);
        idle();
        tick("s3_empty", 3'b011, 3'b011, 8'h00);
        chk("s3.halted_b", 32'(bb.halted), 1);
        chk("s3.halted_n", 32'(bn.halted), 1);
        id_valid = 1;
        tick("s3_hold", 3'b011, 3'b011, 8'h00);
        chk("s3.hold", 32'(bb.halted), 1);

        idle(); rst = 1'b0; sc_b = '0; sc_n = '0;
        tick("rst2", 3'b001, 3'b001, 8'h00);
        chk("rst2.halted", 32'(bn.halted), 0);
        rst = 1'b1;

        // HALT squashed during drain
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 4;
        tick("s3b_w", 3'b100, 3'b100, 8'h10);
        idle(); id_valid = 1; id_halt = 1;
        tick("s3b_halt", 3'b100, 3'b100, 8'h10);
        idle(); flush = 1;
        tick("s3b_flush", 3'b011, 3'b011, 8'h10);
        idle(); id_valid = 1;
        tick("s3b_run", 3'b100, 3'b100, 8'h10);
        chk("s3b.halted", 32'(bb.halted), 0);
        idle(); wb_en = 1; wb_reg = 4;
        tick("s3b_rt", 3'b001, 3'b001, 8'h00);

        // reset mid-operation drops the in-flight writer
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 6;
        tick("s4_w6", 3'b100, 3'b100, 8'h40);
        idle(); rst = 1'b0; sc_b = '0; sc_n = '0;
        tick("rst3", 3'b001, 3'b001, 8'h00);
        rst = 1'b1;
        idle(); id_valid = 1; id_rd1_en = 1; id_rd1 = 6;
        tick("s4_rd6", 3'b100, 3'b100, 8'h00);

        // underflow sets sticky err
        idle(); wb_en = 1; wb_reg = 2;
        tick("s4_under", 3'b001, 3'b001, 8'h00);
        chk("s4.err_b", 32'(bb.err), 1);
        chk("s4.err_n", 32'(bn.err), 1);
        idle();
        tick("s4_sticky", 3'b001, 3'b001, 8'h00);
        chk("s4.sticky", 32'(bb.err), 1);
        rst = 1'b0;
        tick("rst4", 3'b001, 3'b001, 8'h00);
        chk("rst4.err", 32'(bb.err), 0);
        rst = 1'b1;

        // flush beats hazard
        idle(); id_valid = 1; id_wr_en = 1; id_wr = 1;
        tick("s5_w1", 3'b100, 3'b100, 8'h02);
        idle(); id_valid = 1; id_rd2_en = 1; id_rd2 = 1; flush = 1;
        tick("s5_flush", 3'b001, 3'b001, 8'h02);
        flush = 0;
        tick("s5_raw", 3'b011, 3'b011, 8'h02);
        wb_en = 1; wb_reg = 1;
        tick("s5_wb", 3'b100, 3'b011, 8'h00);
        wb_en = 0;
        tick("s5_after", 3'b100, 3'b100, 8'h00);
        idle();
        tick("s5_idle", 3'b001, 3'b001, 8'h00);

        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
